// File: rtl/sprite_bank.sv
// sprite_bank: line-sprite engine holding NSPR sprite slots.
//
// Each slot has staging registers that are written during sprite fetch and an
// active set (plane shift registers, x countdown, attributes, sprite-0 flag)
// that is swapped in at line start by `commit`. On every rendered pixel the
// lowest-index opaque slot wins the priority mux. The winning pixel is
// registered, so there is one cycle of latency and no combinational path from
// any input to any output.
//
// Ports:
//   clk       pixel clock
//   rst_n     synchronous active-low reset
//   load_en   write pattern byte into staging plane plane_i of slot load_idx
//   load_idx  target slot of the staging write
//   plane_i   bit-plane carried by pat_i; the last plane also latches attr/x/sp0
//   pat_i     pattern byte, MSB = leftmost pixel
//   at_i      OAM attribute: [1:0] palette, [5] priority, [6] flip-x
//   x_i       OAM x coordinate (pixels to wait before the sprite starts)
//   inscan_i  0 forces the loaded pattern to transparent
//   sp0_i     slot being loaded is OAM sprite 0
//   commit    line start: copy every staging slot into its active slot
//   frame_on  a visible pixel is rendered this cycle
//   px_o      {palette, plane bits MSB-plane first}; 0 = transparent
//   pri_o     priority bit of the winning slot (1 = behind background)
//   sp0_o     sprite 0 is opaque at this pixel
module sprite_bank #(
  parameter int NSPR = 8,
  parameter int BPP  = 2,
  localparam int IW = (NSPR > 1) ? $clog2(NSPR) : 1,
  localparam int PW = (BPP  > 1) ? $clog2(BPP)  : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load_en,
  input  logic [IW-1:0]  load_idx,
  input  logic [PW-1:0]  plane_i,
  input  logic [7:0]     pat_i,
  input  logic [7:0]     at_i,
  input  logic [7:0]     x_i,
  input  logic           inscan_i,
  input  logic           sp0_i,
  input  logic           commit,
  input  logic           frame_on,
  output logic [BPP+1:0] px_o,
  output logic           pri_o,
  output logic           sp0_o
);

  // Staging set, filled during sprite fetch.
  logic [7:0]     r_stg_pat [NSPR][BPP];
  logic [1:0]     r_stg_pal [NSPR];
  logic           r_stg_pri [NSPR];
  logic [7:0]     r_stg_x   [NSPR];
  logic           r_stg_sp0 [NSPR];

  // Active set, used while the line is rendered.
  logic [7:0]     r_sh      [NSPR][BPP];
  logic [7:0]     r_cnt     [NSPR];
  logic [1:0]     r_pal     [NSPR];
  logic           r_pri_a   [NSPR];
  logic           r_sp0_a   [NSPR];

  // Registered outputs.
  logic [BPP+1:0] r_px;
  logic           r_pri;
  logic           r_sp0;

  logic [7:0]     w_raw;
  logic [7:0]     w_pat;
  logic [BPP-1:0] w_bits [NSPR];
  logic           w_opq  [NSPR];
  logic [BPP+1:0] w_px;
  logic           w_pri;
  logic           w_sp0;
  logic           w_found;

  // Attribute bits with no function in this block.
  logic           w_unused;
  assign w_unused = ^{at_i[7], at_i[4:2]};

  // Pattern as stored: masked when not in scan, mirrored when flip-x is set.
  always_comb begin
    w_raw = inscan_i ? pat_i : '0;
    w_pat = '0;
    for (int unsigned b = 0; b < 8; b++) begin
      w_pat[b] = at_i[6] ? w_raw[7-b] : w_raw[b];
    end
  end

  // Staging writes. Matching against every slot/plane index means that
  // out-of-range load_idx or plane_i simply matches nothing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < NSPR; s++) begin
        for (int unsigned p = 0; p < BPP; p++) begin
          r_stg_pat[s][p] <= '0;
        end
        r_stg_pal[s] <= '0;
        r_stg_pri[s] <= 1'b0;
        r_stg_x[s]   <= '0;
        r_stg_sp0[s] <= 1'b0;
      end
    end else if (load_en) begin
      for (int unsigned s = 0; s < NSPR; s++) begin
        if (load_idx == IW'(s)) begin
          for (int unsigned p = 0; p < BPP; p++) begin
            if (plane_i == PW'(p)) begin
              r_stg_pat[s][p] <= w_pat;
            end
          end
          if (plane_i == PW'(BPP - 1)) begin
            r_stg_pal[s] <= at_i[1:0];
            r_stg_pri[s] <= at_i[5];
            r_stg_x[s]   <= x_i;
            r_stg_sp0[s] <= sp0_i;
          end
        end
      end
    end
  end

  // Active slots: commit wins over shifting/counting. An exhausted slot keeps
  // shifting zeros, which leaves it transparent for the rest of the line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < NSPR; s++) begin
        for (int unsigned p = 0; p < BPP; p++) begin
          r_sh[s][p] <= '0;
        end
        r_cnt[s]   <= '0;
        r_pal[s]   <= '0;
        r_pri_a[s] <= 1'b0;
        r_sp0_a[s] <= 1'b0;
      end
    end else if (commit) begin
      for (int unsigned s = 0; s < NSPR; s++) begin
        for (int unsigned p = 0; p < BPP; p++) begin
          r_sh[s][p] <= r_stg_pat[s][p];
        end
        r_cnt[s]   <= r_stg_x[s];
        r_pal[s]   <= r_stg_pal[s];
        r_pri_a[s] <= r_stg_pri[s];
        r_sp0_a[s] <= r_stg_sp0[s];
      end
    end else if (frame_on) begin
      for (int unsigned s = 0; s < NSPR; s++) begin
        if (r_cnt[s] != '0) begin
          r_cnt[s] <= r_cnt[s] - 8'd1;
        end else begin
          for (int unsigned p = 0; p < BPP; p++) begin
            r_sh[s][p] <= {r_sh[s][p][6:0], 1'b0};
          end
        end
      end
    end
  end

  // Per-slot pixel and opacity. A slot only shows while its countdown is at
  // zero on a rendered, non-commit cycle.
  always_comb begin
    for (int unsigned s = 0; s < NSPR; s++) begin
      w_bits[s] = '0;
      for (int unsigned p = 0; p < BPP; p++) begin
        w_bits[s][p] = r_sh[s][p][7];
      end
      w_opq[s] = frame_on && !commit && (r_cnt[s] == '0) && (|w_bits[s]);
    end
  end

  // Priority mux: first opaque slot from index 0 wins; sp0 looks at all slots.
  always_comb begin
    w_px    = '0;
    w_pri   = 1'b0;
    w_sp0   = 1'b0;
    w_found = 1'b0;
    for (int unsigned s = 0; s < NSPR; s++) begin
      if (w_opq[s]) begin
        if (!w_found) begin
          w_found = 1'b1;
          w_px    = {r_pal[s], w_bits[s]};
          w_pri   = r_pri_a[s];
        end
        if (r_sp0_a[s]) begin
          w_sp0 = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_px  <= '0;
      r_pri <= 1'b0;
      r_sp0 <= 1'b0;
    end else begin
      r_px  <= w_px;
      r_pri <= w_pri;
      r_sp0 <= w_sp0;
    end
  end

  assign px_o  = r_px;
  assign pri_o = r_pri;
  assign sp0_o = r_sp0;

endmodule

// File: tb/tb_sprite_bank.sv
// Testbench for sprite_bank: two instances (8 slots/2 planes and 64 slots/4
// planes) driven by directed sequences and random stimulus, checked against a
// per-slot behavioural model through expected-output queues.
module tb_sprite_bank;

  typedef struct packed {
    logic       load_en;
    logic [5:0] idx;
    logic [1:0] plane;
    logic [7:0] pat;
    logic [7:0] at;
    logic [7:0] x;
    logic       inscan;
    logic       sp0;
    logic       commit;
    logic       frame_on;
  } stim_t;

  typedef struct packed {
    logic [7:0] px;
    logic       pri;
    logic       sp0;
  } exp_t;

  logic  clk;
  logic  rst_n;
  stim_t sa, sb;

  logic [3:0] a_px;
  logic       a_pri, a_sp0;
  logic [5:0] b_px;
  logic       b_pri, b_sp0;

  int checks   = 0;
  int failures = 0;

  exp_t qa[$];
  exp_t qb[$];

  sprite_bank #(.NSPR(8), .BPP(2)) u_a (
    .clk(clk), .rst_n(rst_n), .load_en(sa.load_en), .load_idx(sa.idx[2:0]),
    .plane_i(sa.plane[0:0]), .pat_i(sa.pat), .at_i(sa.at), .x_i(sa.x),
    .inscan_i(sa.inscan), .sp0_i(sa.sp0), .commit(sa.commit), .frame_on(sa.frame_on),
    .px_o(a_px), .pri_o(a_pri), .sp0_o(a_sp0)
  );

  sprite_bank #(.NSPR(64), .BPP(4)) u_b (
    .clk(clk), .rst_n(rst_n), .load_en(sb.load_en), .load_idx(sb.idx),
    .plane_i(sb.plane), .pat_i(sb.pat), .at_i(sb.at), .x_i(sb.x),
    .inscan_i(sb.inscan), .sp0_i(sb.sp0), .commit(sb.commit), .frame_on(sb.frame_on),
    .px_o(b_px), .pri_o(b_pri), .sp0_o(b_sp0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Active slots are modelled as "original pattern + pixel position + wait
  // count" rather than as shifting registers.
  int         nspr [2] = '{8, 64};
  int         bpp  [2] = '{2, 4};
  logic [7:0] stg_pat [2][64][4];
  logic [7:0] stg_at  [2][64];
  logic [7:0] stg_x   [2][64];
  logic       stg_sp0 [2][64];
  logic [7:0] act_pat [2][64][4];
  logic [7:0] act_at  [2][64];
  int         act_wait[2][64];
  int         act_pos [2][64];
  logic       act_sp0 [2][64];

  task automatic model_step(input int d, input stim_t st, input logic rst, output exp_t e);
    logic [7:0] raw;
    logic [7:0] pat;
    logic [7:0] bits;
    int         win;
    int         idx;
    int         pl;
    e = '0;
    if (!rst) begin
      for (int s = 0; s < 64; s++) begin
        for (int p = 0; p < 4; p++) begin
          stg_pat[d][s][p] = '0;
          act_pat[d][s][p] = '0;
        end
        stg_at[d][s] = '0; stg_x[d][s] = '0; stg_sp0[d][s] = 1'b0;
        act_at[d][s] = '0; act_wait[d][s] = 0; act_pos[d][s] = 0; act_sp0[d][s] = 1'b0;
      end
    end else begin
      if (st.frame_on && !st.commit) begin
        win = -1;
        for (int s = 0; s < nspr[d]; s++) begin
          if (act_wait[d][s] == 0 && act_pos[d][s] < 8) begin
            bits = '0;
            for (int p = 0; p < bpp[d]; p++) bits[p] = act_pat[d][s][p][7 - act_pos[d][s]];
            if (bits != 0) begin
              if (win < 0) begin
                win   = s;
                e.px  = 8'(int'(act_at[d][s][1:0]) * (1 << bpp[d]) + int'(bits));
                e.pri = act_at[d][s][5];
              end
              if (act_sp0[d][s]) e.sp0 = 1'b1;
            end
          end
        end
        for (int s = 0; s < nspr[d]; s++) begin
          if (act_wait[d][s] > 0) act_wait[d][s]--;
          else if (act_pos[d][s] < 8) act_pos[d][s]++;
        end
      end
      if (st.commit) begin
        for (int s = 0; s < nspr[d]; s++) begin
          for (int p = 0; p < bpp[d]; p++) act_pat[d][s][p] = stg_pat[d][s][p];
          act_at[d][s]   = stg_at[d][s];
          act_wait[d][s] = int'(stg_x[d][s]);
          act_pos[d][s]  = 0;
          act_sp0[d][s]  = stg_sp0[d][s];
        end
      end
      if (st.load_en) begin
        idx = (d == 0) ? int'(st.idx[2:0]) : int'(st.idx);
        pl  = (d == 0) ? int'(st.plane[0]) : int'(st.plane);
        if (idx < nspr[d] && pl < bpp[d]) begin
          raw = st.inscan ? st.pat : 8'h00;
          pat = raw;
          if (st.at[6]) for (int i = 0; i < 8; i++) pat[i] = raw[7 - i];
          stg_pat[d][idx][pl] = pat;
          if (pl == bpp[d] - 1) begin
            stg_at[d][idx]  = st.at;
            stg_x[d][idx]   = st.x;
            stg_sp0[d][idx] = st.sp0;
          end
        end
      end
    end
  endtask

  // ---------------- monitors ----------------
  exp_t ma, mb;
  always @(negedge clk) begin
    if (qa.size() > 0) begin
      ma = qa.pop_front();
      checks++;
      if ({8'(a_px), a_pri, a_sp0} !== ma) begin
        failures++;
        $display("FAIL sb_a t=%0t got px=%h pri=%b sp0=%b exp px=%h pri=%b sp0=%b",
                 $time, a_px, a_pri, a_sp0, ma.px, ma.pri, ma.sp0);
      end
    end
    if (qb.size() > 0) begin
      mb = qb.pop_front();
      checks++;
      if ({8'(b_px), b_pri, b_sp0} !== mb) begin
        failures++;
        $display("FAIL sb_b t=%0t got px=%h pri=%b sp0=%b exp px=%h pri=%b sp0=%b",
                 $time, b_px, b_pri, b_sp0, mb.px, mb.pri, mb.sp0);
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic step();
    exp_t ea, eb;
    model_step(0, sa, rst_n, ea);
    qa.push_back(ea);
    model_step(1, sb, rst_n, eb);
    qb.push_back(eb);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sa = '0;
    sb = '0;
  endtask

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
    end
  endtask

  task automatic ld(input int d, input int idx, input int pl, input logic [7:0] pat,
                    input logic [7:0] at, input logic [7:0] x, input logic ins, input logic sp0);
    stim_t t;
    t = '0;
    t.load_en = 1'b1; t.idx = 6'(idx); t.plane = 2'(pl); t.pat = pat;
    t.at = at; t.x = x; t.inscan = ins; t.sp0 = sp0;
    if (d == 0) sa = t; else sb = t;
    step();
    idle();
  endtask

  task automatic stage(input int d, input int idx, input logic [31:0] pats,
                       input logic [7:0] at, input logic [7:0] x, input logic ins, input logic sp0);
    for (int p = 0; p < bpp[d]; p++) ld(d, idx, p, pats[8*p +: 8], at, x, ins, sp0);
  endtask

  task automatic do_commit(input int d);
    if (d == 0) sa.commit = 1'b1; else sb.commit = 1'b1;
    step();
    idle();
  endtask

  task automatic pixel(input int d);
    if (d == 0) sa.frame_on = 1'b1; else sb.frame_on = 1'b1;
    step();
    idle();
  endtask

  task automatic clear_slots(input int d);
    for (int s = 0; s < nspr[d]; s++) stage(d, s, 32'hFFFF_FFFF, 8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic rand_phase(input int d, input int n);
    stim_t t;
    for (int i = 0; i < n; i++) begin
      t = '0;
      t.load_en  = ($urandom_range(0, 1) == 1);
      t.idx      = 6'($urandom_range(0, nspr[d] - 1));
      t.plane    = 2'($urandom_range(0, bpp[d] - 1));
      t.pat      = 8'($urandom);
      t.at       = 8'($urandom);
      t.x        = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
      t.inscan   = ($urandom_range(0, 4) != 0);
      t.sp0      = ($urandom_range(0, 7) == 0);
      t.commit   = ($urandom_range(0, 19) == 0);
      t.frame_on = ($urandom_range(0, 3) != 0);
      if (d == 0) sa = t; else sb = t;
      rst_n = ($urandom_range(0, 299) != 0);
      step();
    end
    idle();
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t got=running exp=finished", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 1'b0;
    idle();
    repeat (3) step();
    chk("reset_a", 8'({a_px, a_pri, a_sp0}), 8'h00);
    chk("reset_b", 8'({b_px, b_pri, b_sp0}), 8'h00);
    rst_n = 1'b1;

    // Reset in the middle of a line.
    stage(0, 0, 32'h0000_FFFF, 8'h00, 8'd0, 1'b1, 1'b0);
    do_commit(0);
    repeat (3) pixel(0);
    rst_n = 1'b0;
    sa.frame_on = 1'b1;
    step();
    idle();
    chk("midreset", 8'(a_px), 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pixel(0);
      chk("after_reset", 8'(a_px), 8'h00);
    end

    // Countdown of 3 pixels then one opaque pixel.
    stage(0, 2, 32'h0000_0080, 8'h01, 8'd3, 1'b1, 1'b0);
    do_commit(0);
    for (int i = 0; i < 11; i++) begin
      pixel(0);
      chk("basic", 8'(a_px), (i == 3) ? 8'h05 : 8'h00);
    end

    // Flip-x on and off.
    clear_slots(0);
    stage(0, 0, 32'h0000_0001, 8'h40, 8'd0, 1'b1, 1'b0);
    do_commit(0);
    for (int i = 0; i < 8; i++) begin
      pixel(0);
      chk("flip_on", 8'(a_px), (i == 0) ? 8'h01 : 8'h00);
    end
    stage(0, 0, 32'h0000_0001, 8'h00, 8'd0, 1'b1, 1'b0);
    do_commit(0);
    for (int i = 0; i < 8; i++) begin
      pixel(0);
      chk("flip_off", 8'(a_px), (i == 7) ? 8'h01 : 8'h00);
    end

    // Priority between slots and sp0 tracking.
    clear_slots(0);
    stage(0, 0, 32'h0000_0000, 8'h00, 8'd10, 1'b1, 1'b0);
    stage(0, 1, 32'h0000_8080, 8'h22, 8'd10, 1'b1, 1'b1);
    stage(0, 3, 32'h0000_0080, 8'h03, 8'd10, 1'b1, 1'b0);
    do_commit(0);
    for (int i = 0; i < 12; i++) begin
      pixel(0);
      chk("prio_sp0", 8'({a_px, a_pri, a_sp0}), (i == 10) ? 8'h2F : 8'h00);
    end
    stage(0, 1, 32'h0000_8080, 8'h22, 8'd10, 1'b1, 1'b0);
    do_commit(0);
    for (int i = 0; i < 12; i++) begin
      pixel(0);
      chk("prio_nosp0", 8'({a_px, a_pri, a_sp0}), (i == 10) ? 8'h2E : 8'h00);
    end

    // Out-of-scan load stays transparent.
    clear_slots(0);
    stage(0, 0, 32'h0000_FFFF, 8'h00, 8'd0, 1'b0, 1'b0);
    do_commit(0);
    for (int i = 0; i < 9; i++) begin
      pixel(0);
      chk("inscan0", 8'(a_px), 8'h00);
    end

    // Commit and staging write in the same cycle.
    stage(0, 0, 32'h0000_0080, 8'h00, 8'd0, 1'b1, 1'b0);
    do_commit(0);
    sa.commit = 1'b1; sa.load_en = 1'b1; sa.idx = 6'd0; sa.plane = 2'd0;
    sa.pat = 8'hC0; sa.inscan = 1'b1;
    step();
    idle();
    for (int i = 0; i < 8; i++) begin
      pixel(0);
      chk("same_cyc_old", 8'(a_px), (i == 0) ? 8'h01 : 8'h00);
    end
    do_commit(0);
    for (int i = 0; i < 8; i++) begin
      pixel(0);
      chk("same_cyc_new", 8'(a_px), (i < 2) ? 8'h01 : 8'h00);
    end

    rand_phase(0, 1500);

    // Wide configuration: slot 0 beats all 63 others.
    rst_n = 1'b0; step(); rst_n = 1'b1;
    stage(1, 0, 32'h00FF_00FF, 8'h01, 8'd0, 1'b1, 1'b0);
    for (int s = 1; s < 64; s++) stage(1, s, $urandom, 8'($urandom), 8'd0, 1'b1, 1'b0);
    do_commit(1);
    for (int i = 0; i < 8; i++) begin
      pixel(1);
      chk("wide_slot0", 8'(b_px), 8'h15);
    end

    // Slot 63 shows only where every lower slot is transparent.
    clear_slots(1);
    stage(1, 63, 32'hFFFF_FFFF, 8'h03, 8'd0, 1'b1, 1'b0);
    do_commit(1);
    for (int i = 0; i < 8; i++) begin
      pixel(1);
      chk("wide_slot63", 8'(b_px), 8'h3F);
    end
    stage(1, 5, 32'h0000_000F, 8'h00, 8'd0, 1'b1, 1'b0);
    do_commit(1);
    for (int i = 0; i < 8; i++) begin
      pixel(1);
      chk("wide_slot5", 8'(b_px), (i < 4) ? 8'h3F : 8'h01);
    end

    rand_phase(1, 800);

    repeat (2) step();
    @(negedge clk);
    #1;
    chk("queues_drained", 8'(qa.size() + qb.size()), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sprite_bank.md
Name: sprite_bank

Overview:
- Parametrised line-sprite engine for the PPU.
- Holds NSPR sprite slots. Each slot has staging registers, which are filled during sprite fetch, and active shift registers/x-counters, which are swapped in at line start.
- Each pixel clock, the block selects the lowest-index opaque sprite and emits a registered pixel, its priority bit, and a sprite-0 opaque flag for the hit logic.
- Generalises the single-slot sprite unit: configurable slot count and bits per pixel, with the priority mux and sprite-0 tracking built in.

Parameters:
- NSPR, 8, number of sprite slots (1..64; 64 = no per-line sprite limit mode).
- BPP, 2, pattern bit-planes per pixel (1..4).
- IW, $clog2(NSPR) (min 1), derived localparam: slot index width.
- PW, $clog2(BPP) (min 1), derived localparam: plane index width.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  reset, synchronous, active-low.
- load_en  in  1  write staging data for slot load_idx this cycle.
- load_idx  in  IW  target slot for the staging write.
- plane_i  in  PW  bit-plane number carried by pat_i.
- pat_i  in  8  pattern byte for plane_i, MSB = leftmost pixel.
- at_i  in  8  OAM attribute byte: [1:0] palette, [5] priority, [6] flip-x.
- x_i  in  8  OAM x coordinate.
- inscan_i  in  1  slot holds a real in-range sprite; 0 forces the pattern to transparent.
- sp0_i  in  1  slot being loaded is OAM sprite 0.
- commit  in  1  line start: copy all staging registers into active registers.
- frame_on  in  1  visible pixel is being rendered this cycle.
- px_o  out  2+BPP  {palette, pixel bits}; 0 = transparent.
- pri_o  out  1  priority bit of the winning slot (1 = behind background).
- sp0_o  out  1  sprite 0 is opaque at this pixel.

Behaviour:
- Reset (rst_n=0 at posedge): every staging register, shift register, counter, valid flag and output clears to 0.
  - Outputs read px_o=0, pri_o=0, sp0_o=0 on the cycle after reset is sampled.
- Staging write (load_en=1):
  - pattern = inscan_i ? pat_i : 0.
  - If at_i[6]=1, the pattern is bit-reversed before storage.
  - The result is stored in plane plane_i of slot load_idx.
  - When plane_i==BPP-1, at_i, x_i and sp0_i are also latched into that slot.
  - Out-of-range plane_i or load_idx (≥BPP / ≥NSPR) is ignored.
- Commit (commit=1), for every slot:
  - Shift registers ← staged planes.
  - Counter ← staged x.
  - Active attr ← staged attr.
  - Active sp0 ← staged sp0.
  - Commit has precedence: no shift and no decrement occur that cycle.
  - Same-cycle load_en and commit: the commit copies the pre-write staging value; the write lands in staging only.
- Per slot, when frame_on=1 and not commit:
  - Counter ≠ 0: decrement by 1; the slot is transparent this cycle.
  - Counter == 0: the slot is enabled. Its pixel is bit 7 of each plane; every plane shifts left 1 with 0 filled in.
  - After 8 shifts the slot is exhausted and transparent.
  - The counter never wraps below 0.
- frame_on=0 and no commit: all active state holds.
- Priority mux:
  - A slot is opaque if enabled and any plane bit 7 is 1.
  - The winner is the lowest-index opaque slot.
  - px_o ← {attr[1:0], plane bits MSB-plane first}.
  - pri_o ← attr[5].
  - No opaque slot: px_o=0 and pri_o=0.
- sp0_o ← 1 if any opaque slot has active sp0=1, regardless of which slot wins.
- Latency: outputs are registered, so pixel data sampled on cycle N appears on cycle N+1.
  - With frame_on=0, outputs register 0 on the next cycle.
- Single registered output stage; no combinational path from inputs to outputs.

Test Plan:
- Reset mid-line: stage and commit slot 0 (x=0, planes FF/FF), run 3 pixels, drop rst_n → next cycle px_o=0; all later pixels stay 0 until a new load and commit.
- Basic timing: slot 2 gets x=3, at=0x01, planes 0x80/0x00, then commit, then frame_on from cycle 0 → px_o=0 on output cycles 1..3, px_o={01,0,1}=0x5 on output cycle 4, then 0 for the remaining 7 pixels.
- Flip-x: load pat 0x01 with at[6]=1 at x=0 → opaque on the first pixel. The same load with at[6]=0 → opaque only on the 8th pixel.
- Priority and sp0: slot 0 is transparent at x=10; slot 1 (sp0=1, pri=1) and slot 3 (pri=0) are both opaque at x=10 → px_o from slot 1, pri_o=1, sp0_o=1. Clearing slot 1's sp0 → sp0_o=0 with identical px_o.
- inscan_i=0 load with pat 0xFF → slot never opaque. Same-cycle commit+load_en → the committed line uses the old data, and the new data appears after the next commit.
- Parameter sweep: NSPR=64, BPP=4 with all slots at x=0 → slot 0 wins every pixel and px_o width is 6. Slot 63 becomes visible only when slots 0..62 are transparent.
